// File: rtl/aircraft_request_sequencer.sv
// Aircraft-side request sequencer for the runway controller.
// Landing requests are queued in a small FIFO. The head request is presented
// to the controller as d plus a one-cycle en strobe. The returned runway code
// is sampled RESP_WAIT cycles after en falls. A grant pops the head. A hold
// puts the head into backoff and then reissues it, and the head is aborted
// once it has been held MAX_RETRY times.
//
// Ports:
//   clk, rst          system clock; synchronous active-high reset
//   req_valid/ready   request push handshake; req_type is the aircraft class
//   d, en             class and strobe presented to the controller
//   signal            4-bit runway code returned by the controller
//   land_valid        1-cycle grant pulse, with land_runway (0=A, 1=B) and land_type
//   abort             1-cycle pulse when the head is dropped after MAX_RETRY holds
//   bad_code          1-cycle pulse when the sampled code is not recognised
//   pending           FIFO occupancy
//   busy              FSM is not idle
//
// state     | meaning
// S_IDLE    | waiting for a queued request
// S_ISSUE   | en high, d carries the head class
// S_WAIT    | en low, counting RESP_WAIT cycles, then sample and decode signal
// S_BACKOFF | head was held, counting BACKOFF cycles before reissue
module aircraft_request_sequencer #(
  parameter int DEPTH     = 4,
  parameter int RESP_WAIT = 1,
  parameter int BACKOFF   = 16,
  parameter int MAX_RETRY = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  input  logic [1:0]               req_type,
  output logic                     req_ready,
  output logic [1:0]               d,
  output logic                     en,
  input  logic [3:0]               signal,
  output logic                     land_valid,
  output logic                     land_runway,
  output logic [1:0]               land_type,
  output logic                     abort,
  output logic                     bad_code,
  output logic [$clog2(DEPTH):0]   pending,
  output logic                     busy
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CMAX = (BACKOFF > RESP_WAIT) ? BACKOFF : RESP_WAIT;
  localparam int CW   = $clog2(CMAX) + 1;
  localparam int RW   = 4;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_BACKOFF} state_t;

  state_t          state, state_nxt;
  logic [1:0]      fifo_mem [DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [RW-1:0]   retry, retry_nxt;
  logic [1:0]      head, d_nxt;
  logic            push, pop;
  logic            en_nxt, land_valid_nxt, land_runway_nxt, abort_nxt, bad_code_nxt;

  assign head      = fifo_mem[rd_ptr];
  // Readiness comes from the pre-pop occupancy, so a full FIFO refuses a push
  // even on the cycle the head is popped.
  assign req_ready = (pending != FULL);
  assign push      = req_valid && req_ready;
  assign busy      = (state != S_IDLE);

  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt + 1'b1;
    retry_nxt       = retry;
    d_nxt           = d;
    en_nxt          = 1'b0;
    land_valid_nxt  = 1'b0;
    land_runway_nxt = 1'b0;
    abort_nxt       = 1'b0;
    bad_code_nxt    = 1'b0;
    pop             = 1'b0;
    case (state)
      S_IDLE: begin
        if (pending != '0) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (cnt == CW'(RESP_WAIT - 1)) begin
          if (signal == 4'b1010 || signal == 4'b1011) begin
            land_valid_nxt  = 1'b1;
            land_runway_nxt = signal[0];
            pop             = 1'b1;
            retry_nxt       = '0;
            state_nxt       = S_IDLE;
          end else begin
            // Unrecognised codes are flagged and then handled exactly like a hold.
            bad_code_nxt = (signal != 4'b1101);
            if (retry == RW'(MAX_RETRY - 1)) begin
              abort_nxt = 1'b1;
              pop       = 1'b1;
              retry_nxt = '0;
              state_nxt = S_IDLE;
            end else begin
              retry_nxt = retry + 1'b1;
              state_nxt = S_BACKOFF;
            end
          end
        end
      end
      S_BACKOFF: begin
        if (cnt == CW'(BACKOFF - 1)) state_nxt = S_ISSUE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (state_nxt != state) cnt_nxt = '0;
    // d is loaded only on entry to ISSUE, so it stays put through WAIT and
    // later pushes cannot disturb the request in flight.
    if (state_nxt == S_ISSUE) begin
      en_nxt = 1'b1;
      d_nxt  = head;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      retry       <= '0;
      d           <= '0;
      en          <= 1'b0;
      land_valid  <= 1'b0;
      land_runway <= 1'b0;
      land_type   <= '0;
      abort       <= 1'b0;
      bad_code    <= 1'b0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      pending     <= '0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      retry       <= retry_nxt;
      d           <= d_nxt;
      en          <= en_nxt;
      land_valid  <= land_valid_nxt;
      land_runway <= land_runway_nxt;
      abort       <= abort_nxt;
      bad_code    <= bad_code_nxt;
      if (land_valid_nxt) land_type <= head;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      pending <= pending + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= req_type;
  end

endmodule

// File: tb/tb_aircraft_request_sequencer.sv
module tb_aircraft_request_sequencer;
  localparam int DEPTH     = 4;
  localparam int RESP_WAIT = 1;
  localparam int BACKOFF   = 16;
  localparam int MAX_RETRY = 7;

  localparam int K_LAND  = 0;
  localparam int K_ABORT = 1;
  localparam int K_BAD   = 2;

  typedef struct {
    int         kind;
    logic       rw;
    logic [1:0] ty;
    int         cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [1:0]  req_type = 2'b00;
  logic        req_ready;
  logic [1:0]  d;
  logic        en;
  logic [3:0]  signal = 4'b0000;
  logic        land_valid, land_runway, abort, bad_code, busy;
  logic [1:0]  land_type;
  logic [$clog2(DEPTH):0] pending;

  aircraft_request_sequencer #(
    .DEPTH(DEPTH), .RESP_WAIT(RESP_WAIT), .BACKOFF(BACKOFF), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_type(req_type),
    .req_ready(req_ready), .d(d), .en(en), .signal(signal),
    .land_valid(land_valid), .land_runway(land_runway), .land_type(land_type),
    .abort(abort), .bad_code(bad_code), .pending(pending), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // inputs as seen by the DUT on the most recent edge
  logic       e_rst = 1'b1;
  logic       e_push = 1'b0;
  logic [1:0] e_type = 2'b00;

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    e_rst  <= rst;
    e_push <= req_valid;
    e_type <= req_type;
  end

  logic [1:0] tq[$];      // reference FIFO of aircraft classes
  exp_t       eq[$];      // scoreboard of expected output pulses
  logic [3:0] script[$];  // scripted controller responses
  bit         force_hold = 1'b0;
  int         mcnt = 0;

  task automatic chk(input string name, input bit ok, input int act, input int req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d cycle=%0d", name, act, req, cyc);
    end
  endtask

  // Controller model: answers every en strobe and records the outcome it implies.
  int         holds = 0;
  bit         has_last = 1'b0;
  bit         last_hold = 1'b0;
  int         last_en = 0;
  bit         d_chk = 1'b0;
  logic [1:0] d_prev = 2'b00;

  always @(negedge clk) begin : responder
    logic [3:0] code;
    logic [1:0] ty;
    int         r;
    int         t;
    if (e_rst) begin
      holds    = 0;
      has_last = 1'b0;
      d_chk    = 1'b0;
    end else begin
      if (d_chk) chk("d_stable_after_en", d == d_prev, int'(d), int'(d_prev));
      d_chk = 1'b0;
      if (en) begin
        ty = (tq.size() > 0) ? tq[0] : 2'b00;
        chk("issue_nonempty", tq.size() > 0, tq.size(), 1);
        chk("d_head", d == ty, int'(d), int'(ty));
        if (has_last) begin
          if (last_hold)
            chk("hold_reissue_spacing", cyc - last_en == 1 + RESP_WAIT + BACKOFF,
                cyc - last_en, 1 + RESP_WAIT + BACKOFF);
          else
            chk("issue_spacing", cyc - last_en >= 2 + RESP_WAIT, cyc - last_en, 2 + RESP_WAIT);
        end
        if (script.size() > 0) code = script.pop_front();
        else if (force_hold) code = 4'b1101;
        else begin
          r = $urandom_range(0, 9);
          if (r < 3) code = 4'b1010;
          else if (r < 6) code = 4'b1011;
          else if (r < 9) code = 4'b1101;
          else begin
            do code = 4'($urandom_range(0, 15));
            while (code == 4'b1010 || code == 4'b1011 || code == 4'b1101);
          end
        end
        signal = code;
        t = cyc + 1 + RESP_WAIT;
        if (code == 4'b1010 || code == 4'b1011) begin
          eq.push_back('{kind: K_LAND, rw: code[0], ty: ty, cyc: t});
          holds     = 0;
          last_hold = 1'b0;
        end else begin
          if (code != 4'b1101) eq.push_back('{kind: K_BAD, rw: 1'b0, ty: ty, cyc: t});
          holds++;
          if (holds == MAX_RETRY) begin
            eq.push_back('{kind: K_ABORT, rw: 1'b0, ty: ty, cyc: t});
            holds     = 0;
            last_hold = 1'b0;
          end else begin
            last_hold = 1'b1;
          end
        end
        last_en  = cyc;
        has_last = 1'b1;
        d_prev   = d;
        d_chk    = 1'b1;
      end
    end
  end

  // Monitor: compares DUT pulses against the scoreboard and tracks occupancy.
  always @(negedge clk) begin : monitor
    bit   gl, ga, gb, acc;
    int   popped;
    exp_t x;
    if (e_rst) begin
      mcnt = 0;
      tq.delete();
      eq.delete();
      chk("rst_en", en == 1'b0, int'(en), 0);
      chk("rst_d", d == 2'b00, int'(d), 0);
      chk("rst_pending", pending == '0, int'(pending), 0);
      chk("rst_req_ready", req_ready == 1'b1, int'(req_ready), 1);
      chk("rst_busy", busy == 1'b0, int'(busy), 0);
      chk("rst_pulses", {land_valid, abort, bad_code} == 3'b000,
          int'({land_valid, abort, bad_code}), 0);
    end else begin
      gl = land_valid;
      ga = abort;
      gb = bad_code;
      popped = 0;
      while (eq.size() > 0 && eq[0].cyc <= cyc) begin
        x = eq.pop_front();
        if (x.kind == K_BAD) begin
          chk("bad_code", gb && x.cyc == cyc, int'(gb), 1);
          gb = 1'b0;
        end else if (x.kind == K_LAND) begin
          chk("land_valid", gl && x.cyc == cyc, int'(gl), 1);
          chk("land_runway", land_runway == x.rw, int'(land_runway), int'(x.rw));
          chk("land_type", land_type == x.ty, int'(land_type), int'(x.ty));
          gl = 1'b0;
          popped++;
        end else begin
          chk("abort", ga && x.cyc == cyc, int'(ga), 1);
          ga = 1'b0;
          popped++;
        end
      end
      chk("no_unexpected_pulse", !(gl || ga || gb), int'({gl, ga, gb}), 0);
      acc = e_push && (mcnt < DEPTH);
      repeat (popped) if (tq.size() > 0) void'(tq.pop_front());
      if (acc) tq.push_back(e_type);
      mcnt = mcnt + int'(acc) - popped;
      chk("pending", int'(pending) == mcnt, int'(pending), mcnt);
      chk("req_ready", req_ready == (mcnt < DEPTH), int'(req_ready), int'(mcnt < DEPTH));
    end
  end

  task automatic push_one(input logic [1:0] t);
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_type  = t;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    repeat (2) begin @(negedge clk); #1; end
    while ((tq.size() != 0 || eq.size() != 0 || busy) && n < 3000) begin
      @(negedge clk); #1;
      n++;
    end
    chk("drain_within_budget", n < 3000, n, 3000);
  endtask

  initial begin : watchdog
    repeat (80000) @(posedge clk);
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int n;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // single grant on runway A
    script.push_back(4'b1010);
    push_one(2'b01);
    wait_idle();

    // two back-to-back requests granted B then A
    script.push_back(4'b1011);
    script.push_back(4'b1010);
    @(posedge clk); #1;
    req_valid = 1'b1; req_type = 2'b00;
    @(posedge clk); #1;
    req_type = 2'b10;
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_idle();

    // two holds then a grant on B
    script.push_back(4'b1101);
    script.push_back(4'b1101);
    script.push_back(4'b1011);
    push_one(2'b11);
    wait_idle();

    // permanent hold: both entries abort after MAX_RETRY holds each
    force_hold = 1'b1;
    push_one(2'b01);
    push_one(2'b10);
    wait_idle();

    // overfill: fifth push is refused while the head is being held
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      req_valid = 1'b1;
      req_type  = 2'($urandom_range(0, 3));
    end
    @(negedge clk);
    chk("full_pending", int'(pending) == DEPTH, int'(pending), DEPTH);
    chk("full_not_ready", req_ready == 1'b0, int'(req_ready), 0);
    @(posedge clk); #1;
    req_valid  = 1'b0;
    force_hold = 1'b0;
    // keep pushing while entries drain
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      req_valid = (i < 120);
      req_type  = 2'($urandom_range(0, 3));
    end
    req_valid = 1'b0;
    wait_idle();

    // unrecognised code, then a grant after backoff
    script.push_back(4'b0000);
    script.push_back(4'b1010);
    push_one(2'b10);
    wait_idle();

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      req_valid = ($urandom_range(0, 3) == 0);
      req_type  = 2'($urandom_range(0, 3));
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_idle();

    // reset while en is high: the in-flight grant is discarded
    script.push_back(4'b1010);
    push_one(2'b11);
    n = 0;
    while (!en && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("en_seen_before_reset", n < 50, n, 50);
    rst = 1'b1;
    @(negedge clk);
    chk("reset_drops_en", en == 1'b0, int'(en), 0);
    chk("reset_clears_pending", pending == '0, int'(pending), 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
